mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 138 +++++++++++++
 tb/tb_mem_access_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the EX/MEM stage and a simple
// ready-handshaked data bus. It aligns stores onto byte lanes, extracts and
// extends loads, stalls the pipeline while a bus access is outstanding, and
// abandons an access with a one-cycle error pulse if the bus never answers.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_write_data,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wstrb,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_stall,
    output logic [31:0] o_mem_read_data,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [3:0]  wait_count;
    logic        request;
    logic        is_byte;
    logic        is_half;
    logic        misaligned;
    logic        timeout;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;

    assign request    = i_mem_read | i_mem_write;
    assign is_byte    = (i_size == 2'b00);
    assign is_half    = (i_size == 2'b01);
    assign misaligned = (is_half & i_addr[0]) |
                        (~is_byte & ~is_half & (i_addr[1:0] != 2'b00));
    assign timeout    = (wait_count == 4'd15) & ~i_bus_ready;

    // The fault flag only means something while a new request is being decoded.
    assign o_misaligned = (state == IDLE) & request & misaligned;

    // Bus request and stall are forced low while reset is held, even mid-access.
    assign o_bus_req  = reset & (state == ACCESS);
    assign o_stall    = reset & ((state == ACCESS) |
                                 ((state == IDLE) & request & ~misaligned));
    assign o_bus_we   = ~i_mem_read;
    assign o_bus_addr = {i_addr[31:2], 2'b00};

    // Next-state decision; DONE always lasts exactly one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (request & ~misaligned) next_state = ACCESS;
            ACCESS:  if (i_bus_ready | (wait_count == 4'd15)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Store lane strobes and replicated write data; size 11 behaves as a word.
    always_comb begin
        o_bus_wstrb = 4'b1111;
        o_bus_wdata = i_write_data;
        if (is_byte) begin
            case (i_addr[1:0])
                2'd0:    o_bus_wstrb = 4'b0001;
                2'd1:    o_bus_wstrb = 4'b0010;
                2'd2:    o_bus_wstrb = 4'b0100;
                default: o_bus_wstrb = 4'b1000;
            endcase
            o_bus_wdata = {4{i_write_data[7:0]}};
        end else if (is_half) begin
            o_bus_wstrb = i_addr[1] ? 4'b1100 : 4'b0011;
            o_bus_wdata = {2{i_write_data[15:0]}};
        end
    end

    // Pick the addressed lane out of the bus word and sign- or zero-extend it.
    always_comb begin
        case (i_addr[1:0])
            2'd0:    load_byte = i_bus_rdata[7:0];
            2'd1:    load_byte = i_bus_rdata[15:8];
            2'd2:    load_byte = i_bus_rdata[23:16];
            default: load_byte = i_bus_rdata[31:24];
        endcase
        load_half = i_addr[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        if (is_byte) begin
            load_value = {{24{~i_unsigned & load_byte[7]}}, load_byte};
        end else if (is_half) begin
            load_value = {{16{~i_unsigned & load_half[15]}}, load_half};
        end else begin
            load_value = i_bus_rdata;
        end
    end

    // State, wait counter, load data register and the timeout error pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            wait_count      <= 4'd0;
            o_mem_read_data <= 32'd0;
            o_bus_err       <= 1'b0;
        end else begin
            state     <= next_state;
            o_bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    wait_count <= 4'd0;
                end
                ACCESS: begin
                    if (i_bus_ready) begin
                        if (i_mem_read) o_mem_read_data <= load_value;
                    end else if (timeout) begin
                        o_bus_err <= 1'b1;
                        if (i_mem_read) o_mem_read_data <= 32'd0;
                    end else begin
                        wait_count <= wait_count + 4'd1;
                    end
                end
                default: begin
                    wait_count <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven and randomized checks of the load/store
// unit against an arithmetic reference model, plus hand-written sequences for
// misalignment, bus timeout and reset in the middle of an access.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_addr;
    logic [31:0] i_write_data;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_wstrb;
    logic        i_bus_ready;
    logic [31:0] i_bus_rdata;
    logic        o_stall;
    logic [31:0] o_mem_read_data;
    logic        o_misaligned;
    logic        o_bus_err;

    int checkCount;
    int passCount;
    logic [31:0] modelRead;

    typedef struct {
        bit          isRead;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] expAddr;
        logic [3:0]  expStrb;
        logic [31:0] expWdata;
        logic [31:0] expRead;
    } vector_t;

    vector_t vectors[9];

    mem_access_unit dut (
        .clk             (clk),
        .reset           (reset),
        .i_mem_read      (i_mem_read),
        .i_mem_write     (i_mem_write),
        .i_size          (i_size),
        .i_unsigned      (i_unsigned),
        .i_addr          (i_addr),
        .i_write_data    (i_write_data),
        .o_bus_req       (o_bus_req),
        .o_bus_we        (o_bus_we),
        .o_bus_addr      (o_bus_addr),
        .o_bus_wdata     (o_bus_wdata),
        .o_bus_wstrb     (o_bus_wstrb),
        .i_bus_ready     (i_bus_ready),
        .i_bus_rdata     (i_bus_rdata),
        .o_stall         (o_stall),
        .o_mem_read_data (o_mem_read_data),
        .o_misaligned    (o_misaligned),
        .o_bus_err       (o_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic on byte offsets and sizes.
    function automatic int sizeBytes(input logic [1:0] size);
        if (size == 2'b00) return 1;
        if (size == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit modelMisaligned(input logic [1:0] size, input logic [31:0] addr);
        return (addr % sizeBytes(size)) != 0;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] size, input bit uns,
                                              input logic [31:0] addr, input logic [31:0] rdata);
        int n;
        logic [31:0] v;
        n = sizeBytes(size);
        if (n == 4) return rdata;
        v = (rdata >> (8 * (addr % 4))) % (32'd1 << (8 * n));
        if (!uns && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic logic [3:0] modelStrb(input logic [1:0] size, input logic [31:0] addr);
        int n;
        n = sizeBytes(size);
        return 4'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] modelWdata(input logic [1:0] size, input logic [31:0] wdata);
        int n;
        n = sizeBytes(size);
        if (n == 1) return (wdata % 256) * 32'h0101_0101;
        if (n == 2) return (wdata % 65536) * 32'h0001_0001;
        return wdata;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One full transaction: IDLE decode cycle, ACCESS cycles until ready or
    // timeout (waitCycles >= 16 means the bus never answers), then DONE.
    task automatic applyStimulus(input bit isRead, input logic [1:0] size, input bit uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int waitCycles,
                                 input logic [31:0] expAddr, input logic [3:0] expStrb,
                                 input logic [31:0] expWdata, input logic [31:0] expRead,
                                 input bit expErr);
        @(negedge clk);
        i_mem_read   = isRead;
        i_mem_write  = !isRead;
        i_size       = size;
        i_unsigned   = uns;
        i_addr       = addr;
        i_write_data = wdata;
        i_bus_ready  = 1'b0;
        #1;
        checkOutput("idle_stall", 32'(o_stall), 32'd1);
        checkOutput("idle_misaligned", 32'(o_misaligned), 32'd0);
        checkOutput("idle_bus_req", 32'(o_bus_req), 32'd0);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checkOutput("access_bus_req", 32'(o_bus_req), 32'd1);
            checkOutput("access_stall", 32'(o_stall), 32'd1);
            if (c == 0) begin
                checkOutput("access_we", 32'(o_bus_we), 32'(!isRead));
                checkOutput("access_addr", o_bus_addr, expAddr);
                if (!isRead) begin
                    checkOutput("access_wstrb", 32'(o_bus_wstrb), 32'(expStrb));
                    checkOutput("access_wdata", o_bus_wdata, expWdata);
                end
            end
            if (c == waitCycles) begin
                i_bus_ready = 1'b1;
                i_bus_rdata = rdata;
            end
            @(posedge clk);
            #1;
            i_bus_ready = 1'b0;
            i_bus_rdata = $urandom;
            if (c == waitCycles) break;
        end
        @(negedge clk);
        checkOutput("done_stall", 32'(o_stall), 32'd0);
        checkOutput("done_bus_req", 32'(o_bus_req), 32'd0);
        checkOutput("done_bus_err", 32'(o_bus_err), 32'(expErr));
        checkOutput("done_read_data", o_mem_read_data, expRead);
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
        @(negedge clk);
        checkOutput("after_bus_err", 32'(o_bus_err), 32'd0);
        checkOutput("after_bus_req", 32'(o_bus_req), 32'd0);
        checkOutput("after_read_data", o_mem_read_data, expRead);
        modelRead = expRead;
    endtask

    // A misaligned request must neither stall nor touch the bus or load data.
    task automatic checkMisaligned(input bit isRead, input logic [1:0] size, input logic [31:0] addr);
        @(negedge clk);
        i_mem_read  = isRead;
        i_mem_write = !isRead;
        i_size      = size;
        i_addr      = addr;
        #1;
        checkOutput("misaligned_flag", 32'(o_misaligned), 32'd1);
        checkOutput("misaligned_stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        checkOutput("misaligned_bus_req", 32'(o_bus_req), 32'd0);
        checkOutput("misaligned_read_data", o_mem_read_data, modelRead);
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
        @(negedge clk);
        checkOutput("misaligned_later_req", 32'(o_bus_req), 32'd0);
    endtask

    initial begin
        bit          rIsRead;
        logic [1:0]  rSize;
        bit          rUns;
        logic [31:0] rAddr;
        logic [31:0] rWdata;
        logic [31:0] rRdata;
        logic [31:0] rExpRead;

        checkCount   = 0;
        passCount    = 0;
        modelRead    = 32'd0;
        reset        = 1'b0;
        i_mem_read   = 1'b0;
        i_mem_write  = 1'b0;
        i_size       = 2'b10;
        i_unsigned   = 1'b0;
        i_addr       = 32'd0;
        i_write_data = 32'd0;
        i_bus_ready  = 1'b0;
        i_bus_rdata  = 32'd0;

        vectors[0] = '{1'b1, 2'b00, 1'b0, 32'h103, 32'h0,         32'h80FF_1234, 32'h100, 4'h0, 32'h0,         32'hFFFF_FF80};
        vectors[1] = '{1'b0, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 32'h0,         32'h200, 4'hC, 32'hABCD_ABCD, 32'hFFFF_FF80};
        vectors[2] = '{1'b1, 2'b01, 1'b1, 32'h002, 32'h0,         32'h9ABC_0000, 32'h000, 4'h0, 32'h0,         32'h0000_9ABC};
        vectors[3] = '{1'b1, 2'b01, 1'b0, 32'h002, 32'h0,         32'h9ABC_0000, 32'h000, 4'h0, 32'h0,         32'hFFFF_9ABC};
        vectors[4] = '{1'b1, 2'b10, 1'b0, 32'h304, 32'h0,         32'hDEAD_BEEF, 32'h304, 4'h0, 32'h0,         32'hDEAD_BEEF};
        vectors[5] = '{1'b0, 2'b00, 1'b0, 32'h405, 32'h1234_5678, 32'h0,         32'h404, 4'h2, 32'h7878_7878, 32'hDEAD_BEEF};
        vectors[6] = '{1'b1, 2'b00, 1'b1, 32'h401, 32'h0,         32'h1122_8344, 32'h400, 4'h0, 32'h0,         32'h0000_0083};
        vectors[7] = '{1'b0, 2'b11, 1'b0, 32'h50C, 32'hCAFE_F00D, 32'h0,         32'h50C, 4'hF, 32'hCAFE_F00D, 32'h0000_0083};
        vectors[8] = '{1'b1, 2'b00, 1'b0, 32'h000, 32'h0,         32'h0000_007F, 32'h000, 4'h0, 32'h0,         32'h0000_007F};

        repeat (3) @(negedge clk);
        checkOutput("reset_bus_req", 32'(o_bus_req), 32'd0);
        checkOutput("reset_stall", 32'(o_stall), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_read_data", o_mem_read_data, 32'd0);
        checkOutput("reset_bus_err", 32'(o_bus_err), 32'd0);
        checkOutput("reset_idle_req", 32'(o_bus_req), 32'd0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vectors[i].isRead, vectors[i].size, vectors[i].uns, vectors[i].addr,
                          vectors[i].wdata, vectors[i].rdata, 0, vectors[i].expAddr,
                          vectors[i].expStrb, vectors[i].expWdata, vectors[i].expRead, 1'b0);
        end

        checkMisaligned(1'b1, 2'b10, 32'h101);
        checkMisaligned(1'b0, 2'b01, 32'h203);

        // Bus never answers: 16 ACCESS cycles, error pulse, read data cleared.
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h600, 32'h0, 32'h1111_2222, 16,
                      32'h600, 4'h0, 32'h0, 32'h0, 1'b1);
        // Ready on the 16th ACCESS cycle wins over the timeout.
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h604, 32'h0, 32'h3333_4444, 15,
                      32'h604, 4'h0, 32'h0, 32'h3333_4444, 1'b0);
        // Store timeout: error pulse, load data untouched.
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h608, 32'h5555_6666, 32'h0, 16,
                      32'h608, 4'hF, 32'h5555_6666, 32'h3333_4444, 1'b1);

        // Reset asserted in the middle of an access.
        @(negedge clk);
        i_mem_read  = 1'b1;
        i_mem_write = 1'b0;
        i_size      = 2'b10;
        i_addr      = 32'h700;
        @(negedge clk);
        checkOutput("mid_access_bus_req", 32'(o_bus_req), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("in_reset_bus_req", 32'(o_bus_req), 32'd0);
        checkOutput("in_reset_stall", 32'(o_stall), 32'd0);
        i_mem_read = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_read_data", o_mem_read_data, 32'd0);
        checkOutput("post_reset_bus_err", 32'(o_bus_err), 32'd0);
        reset = 1'b1;
        modelRead = 32'd0;
        @(negedge clk);
        checkOutput("resume_bus_req", 32'(o_bus_req), 32'd0);
        checkOutput("resume_stall", 32'(o_stall), 32'd0);

        for (int n = 0; n < 40; n++) begin
            rIsRead = 1'($urandom);
            rSize   = 2'($urandom);
            rUns    = 1'($urandom);
            rAddr   = $urandom;
            rWdata  = $urandom;
            rRdata  = $urandom;
            if ($urandom_range(0, 3) != 0) rAddr = rAddr - (rAddr % sizeBytes(rSize));
            if (modelMisaligned(rSize, rAddr)) begin
                checkMisaligned(rIsRead, rSize, rAddr);
            end else begin
                rExpRead = rIsRead ? modelLoad(rSize, rUns, rAddr, rRdata) : modelRead;
                applyStimulus(rIsRead, rSize, rUns, rAddr, rWdata, rRdata,
                              int'($urandom_range(0, 3)), {rAddr[31:2], 2'b00},
                              modelStrb(rSize, rAddr), modelWdata(rSize, rWdata),
                              rExpRead, 1'b0);
            end
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
